// File: rtl/vga_fb_scanout.sv
// Frame-buffer scan-out for the VGA path: timing counters, 1-bpp word fetch from
// the frame-buffer read port, a 32-bit pixel serializer and registered DAC outputs.
module vga_fb_scanout #(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter int          ADDR_W   = 16,
    parameter int unsigned FB_BASE  = 0,
    parameter logic [11:0] FG_RGB   = 12'hFFF,
    parameter logic [11:0] BG_RGB   = 12'h000
) (
    input  logic              clock,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vblank,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] H_LAST       = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_VIS_END    = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] H_SYNC_START = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] H_SYNC_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [H_W-1:0] H_MID_END    = H_W'(H_ACTIVE - 32);
    localparam logic [H_W-1:0] H_FETCH_W0   = H_W'(H_TOTAL - 3);

    localparam logic [V_W-1:0] V_LAST       = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_VIS_END    = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] V_VIS_LAST   = V_W'(V_ACTIVE - 1);
    localparam logic [V_W-1:0] V_SYNC_START = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] V_SYNC_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(FB_BASE);

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic [31:0]    shift_q;

    logic        h_wrap;
    logic        v_wrap;
    logic        h_vis;
    logic        v_vis;
    logic        active;
    logic        next_line_vis;
    logic        mid_slot;
    logic        fetch_mid;
    logic        load_mid;
    logic        fetch_first;
    logic        load_first;
    logic [11:0] rgb_d;

    // Register updates land one cycle ahead of the slot they serve: rd_addr
    // changes at the end of 32k-3 so it is stable in 32k-2, and the shift
    // register loads at the end of 32k-1 so word k's bit 0 is live at 32k.
    always_comb begin
        h_wrap        = (h_cnt == H_LAST);
        v_wrap        = (v_cnt == V_LAST);
        h_vis         = (h_cnt < H_VIS_END);
        v_vis         = (v_cnt < V_VIS_END);
        active        = h_vis && v_vis;
        next_line_vis = (v_cnt < V_VIS_LAST) || v_wrap;
        mid_slot      = v_vis && (h_cnt < H_MID_END);
        fetch_mid     = mid_slot && (h_cnt[4:0] == 5'd29);
        load_mid      = mid_slot && (h_cnt[4:0] == 5'd31);
        fetch_first   = next_line_vis && (h_cnt == H_FETCH_W0);
        load_first    = next_line_vis && h_wrap;
        rgb_d         = 12'h000;
        if (active) begin
            rgb_d = shift_q[0] ? FG_RGB : BG_RGB;
        end
    end

    // NOTE: every clocked block uses non-blocking assignments so all state
    // updates see the same pre-edge values regardless of block order.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Word 0 of line 0 is fetched on the last line of the previous frame,
    // which is where the address counter rewinds to the frame base.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr <= BASE_ADDR;
        end else if (fetch_first && v_wrap) begin
            rd_addr <= BASE_ADDR;
        end else if (fetch_first || fetch_mid) begin
            rd_addr <= rd_addr + ADDR_W'(4);
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else if (load_first || load_mid) begin
            shift_q <= rd_data;
        end else if (active) begin
            shift_q <= {1'b0, shift_q[31:1]};
        end
    end

    // All pins are decoded from the same counter state, so they stay aligned.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vga_hs      <= ~((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
            vga_vs      <= ~((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
            vga_r       <= rgb_d[11:8];
            vga_g       <= rgb_d[7:4];
            vga_b       <= rgb_d[3:0];
            vblank      <= ~v_vis;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule
